// File: rtl/vector_processing_element.sv
// rtl/vector_processing_element.sv - multi-lane systolic PE: double-buffered weights, 2-stage MAC/adder-tree pipeline
module vector_processing_element #(
    parameter int DATA_WIDTH             = 8,
    parameter int ACCUMULATOR_DATA_WIDTH = 32,
    parameter int LANES                  = 4,
    parameter int SATURATE               = 1
) (
    input  logic                                CLK,
    input  logic                                SYNC_RST,
    input  logic                                EN,
    input  logic                                LOAD,
    input  logic                                SWAP,
    input  logic                                MODE,
    input  logic                                CLEAR,
    input  logic                                VALID_IN,
    input  logic [LANES*DATA_WIDTH-1:0]         Input,
    input  logic [ACCUMULATOR_DATA_WIDTH-1:0]   PsumIn,
    output logic [LANES*DATA_WIDTH-1:0]         ToRight,
    output logic [ACCUMULATOR_DATA_WIDTH-1:0]   PsumOut,
    output logic                                VALID_OUT,
    output logic                                SAT_FLAG
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = ACCUMULATOR_DATA_WIDTH;
    localparam int PW = 2 * DW;
    localparam int TW = PW + $clog2(LANES);
    // Sum width must hold both the full tree and the accumulator, plus one carry bit
    localparam int SW = ((TW > AW) ? TW : AW) + 1;

    logic signed [DW-1:0] shadow_w [LANES];
    logic signed [DW-1:0] active_w [LANES];
    logic signed [PW-1:0] prod_r   [LANES];
    logic signed [AW-1:0] psum_r;
    logic signed [AW-1:0] acc;
    logic                 mode_r;
    logic                 clear_r;
    logic                 v1;

    logic                 beat;
    logic signed [TW-1:0] tree;
    logic signed [SW-1:0] operand;
    logic signed [SW-1:0] raw;
    logic                 ovf;
    logic        [AW-1:0] result;

    assign beat = VALID_IN & ~LOAD;

    always_comb begin
        tree = '0;
        for (int i = 0; i < LANES; i++) begin
            tree = tree + TW'(prod_r[i]);
        end
    end

    always_comb begin
        operand = SW'(psum_r);
        if (mode_r) begin
            if (clear_r) begin
                operand = '0;
            end else begin
                operand = SW'(acc);
            end
        end
        raw = SW'(tree) + operand;
        // In range only when every bit above the accumulator's sign bit matches it
        ovf = ~((&raw[SW-1:AW-1]) | ~(|raw[SW-1:AW-1]));
        result = raw[AW-1:0];
        if (ovf && (SATURATE != 0)) begin
            result = raw[SW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        end
    end

    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            for (int i = 0; i < LANES; i++) begin
                shadow_w[i] <= '0;
                active_w[i] <= '0;
                prod_r[i]   <= '0;
            end
            psum_r    <= '0;
            acc       <= '0;
            mode_r    <= 1'b0;
            clear_r   <= 1'b0;
            v1        <= 1'b0;
            ToRight   <= '0;
            PsumOut   <= '0;
            VALID_OUT <= 1'b0;
            SAT_FLAG  <= 1'b0;
        end else if (EN) begin
            ToRight <= Input;
            for (int i = 0; i < LANES; i++) begin
                if (SWAP) begin
                    active_w[i] <= shadow_w[i];
                end
                if (LOAD) begin
                    shadow_w[i] <= $signed(Input[i*DW +: DW]);
                end
                if (beat) begin
                    prod_r[i] <= $signed(Input[i*DW +: DW]) * active_w[i];
                end
            end
            v1 <= beat;
            if (beat) begin
                psum_r  <= $signed(PsumIn);
                mode_r  <= MODE;
                clear_r <= CLEAR;
            end
            if (v1) begin
                PsumOut   <= result;
                SAT_FLAG  <= ovf;
                VALID_OUT <= 1'b1;
                if (mode_r) begin
                    acc <= $signed(result);
                end
            end else begin
                VALID_OUT <= 1'b0;
                SAT_FLAG  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vector_processing_element.sv
// tb/tb_vector_processing_element.sv - randomized and directed checks of vector_processing_element against a beat-level model
module tb_vector_processing_element;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        SYNC_RST, EN, LOAD, SWAP, MODE, CLEAR, VALID_IN;
    logic [31:0] Input;
    logic [31:0] PsumIn;
    logic [31:0] tr0, tr1, tr2;
    logic [31:0] po0;
    logic [15:0] po1, po2;
    logic        vo0, vo1, vo2, sf0, sf1, sf2;

    vector_processing_element #(.DATA_WIDTH(8), .ACCUMULATOR_DATA_WIDTH(32), .LANES(4), .SATURATE(1)) dut0 (
        .CLK(CLK), .SYNC_RST(SYNC_RST), .EN(EN), .LOAD(LOAD), .SWAP(SWAP), .MODE(MODE),
        .CLEAR(CLEAR), .VALID_IN(VALID_IN), .Input(Input), .PsumIn(PsumIn),
        .ToRight(tr0), .PsumOut(po0), .VALID_OUT(vo0), .SAT_FLAG(sf0));

    vector_processing_element #(.DATA_WIDTH(8), .ACCUMULATOR_DATA_WIDTH(16), .LANES(4), .SATURATE(1)) dut1 (
        .CLK(CLK), .SYNC_RST(SYNC_RST), .EN(EN), .LOAD(LOAD), .SWAP(SWAP), .MODE(MODE),
        .CLEAR(CLEAR), .VALID_IN(VALID_IN), .Input(Input), .PsumIn(PsumIn[15:0]),
        .ToRight(tr1), .PsumOut(po1), .VALID_OUT(vo1), .SAT_FLAG(sf1));

    vector_processing_element #(.DATA_WIDTH(8), .ACCUMULATOR_DATA_WIDTH(16), .LANES(4), .SATURATE(0)) dut2 (
        .CLK(CLK), .SYNC_RST(SYNC_RST), .EN(EN), .LOAD(LOAD), .SWAP(SWAP), .MODE(MODE),
        .CLEAR(CLEAR), .VALID_IN(VALID_IN), .Input(Input), .PsumIn(PsumIn[15:0]),
        .ToRight(tr2), .PsumOut(po2), .VALID_OUT(vo2), .SAT_FLAG(sf2));

    int tests = 0;
    int fails = 0;
    bit checking = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: weights as integer arrays, each beat's result computed when it is accepted
    int     sh [4];
    int     ac [4];
    longint acc_m [3];
    bit     pend_v;
    longint pend_val [3];
    bit     pend_sat [3];
    bit     exp_v;
    longint exp_po [3];
    bit     exp_sf [3];
    logic [31:0] exp_tr;
    int     aw_c  [3] = '{32, 16, 16};
    int     sat_c [3] = '{1, 1, 0};

    function automatic int lane(input logic [31:0] v, input int i);
        logic [7:0] b;
        b = v[i*8 +: 8];
        return int'($signed(b));
    endfunction

    task automatic fit(input longint raw, input int w, input int s, output longint res, output bit ovf);
        longint mx, mn, t;
        mx = (64'sd1 <<< (w - 1)) - 1;
        mn = -mx - 1;
        ovf = (raw > mx) || (raw < mn);
        t = raw <<< (64 - w);
        t = t >>> (64 - w);
        res = t;
        if (ovf && s != 0) res = (raw > mx) ? mx : mn;
    endtask

    task automatic model_step();
        longint dot, psum, opnd, res;
        bit ovf;
        if (SYNC_RST) begin
            for (int i = 0; i < 4; i++) begin sh[i] = 0; ac[i] = 0; end
            for (int c = 0; c < 3; c++) begin acc_m[c] = 0; exp_po[c] = 0; exp_sf[c] = 0; end
            pend_v = 0; exp_v = 0; exp_tr = '0;
        end else if (EN) begin
            exp_tr = Input;
            exp_v  = pend_v;
            for (int c = 0; c < 3; c++) begin
                if (pend_v) begin exp_po[c] = pend_val[c]; exp_sf[c] = pend_sat[c]; end
                else exp_sf[c] = 0;
            end
            pend_v = VALID_IN && !LOAD;
            if (pend_v) begin
                dot = 0;
                for (int i = 0; i < 4; i++) dot += longint'(lane(Input, i)) * longint'(ac[i]);
                for (int c = 0; c < 3; c++) begin
                    psum = (c == 0) ? longint'($signed(PsumIn)) : longint'($signed(PsumIn[15:0]));
                    opnd = MODE ? (CLEAR ? 0 : acc_m[c]) : psum;
                    fit(dot + opnd, aw_c[c], sat_c[c], res, ovf);
                    pend_val[c] = res;
                    pend_sat[c] = ovf;
                    if (MODE) acc_m[c] = res;
                end
            end
            if (SWAP) for (int i = 0; i < 4; i++) ac[i] = sh[i];
            if (LOAD) for (int i = 0; i < 4; i++) sh[i] = lane(Input, i);
        end
    endtask

    always @(negedge CLK) begin
        if (checking) begin
            check("toright0", tr0, exp_tr);
            check("toright1", tr1, exp_tr);
            check("toright2", tr2, exp_tr);
            check("valid0", vo0, exp_v);
            check("valid1", vo1, exp_v);
            check("valid2", vo2, exp_v);
            check("psum0", $signed(po0), exp_po[0]);
            check("psum1", $signed(po1), exp_po[1]);
            check("psum2", $signed(po2), exp_po[2]);
            check("sat0", sf0, exp_sf[0]);
            check("sat1", sf1, exp_sf[1]);
            check("sat2", sf2, exp_sf[2]);
        end
    end

    task automatic step();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic drive(input bit en, input bit ld, input bit sw, input bit md, input bit cl,
                         input bit vi, input logic [31:0] in, input logic [31:0] ps);
        EN = en; LOAD = ld; SWAP = sw; MODE = md; CLEAR = cl; VALID_IN = vi;
        Input = in; PsumIn = ps;
        step();
    endtask

    initial begin
        SYNC_RST = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        SYNC_RST = 1'b0;
        checking = 1;
        check("rst_psum", po0, 0);
        check("rst_valid", vo0, 0);
        check("rst_toright", tr0, 0);

        // Weights {1,2,3,4}, one MODE0 beat with PsumIn 100
        drive(1, 1, 0, 0, 0, 0, 32'h04030201, 0);
        drive(1, 0, 1, 0, 0, 0, 32'h0, 0);
        drive(1, 0, 0, 0, 0, 1, 32'h01010101, 100);
        check("t2_toright", tr0, 32'h01010101);
        drive(1, 0, 0, 0, 0, 0, 32'h0, 0);
        check("t2_valid", vo0, 1);
        check("t2_psum", $signed(po0), 110);

        // Shadow reload mid-stream; the SWAP-cycle beat still uses old weights
        drive(1, 0, 0, 0, 0, 1, 32'h01010101, 0);
        drive(1, 1, 0, 0, 0, 1, 32'hFFFFFFFF, 0);
        drive(1, 0, 0, 0, 0, 1, 32'h01010101, 0);
        check("t3_load_no_valid", vo0, 0);
        drive(1, 0, 1, 0, 0, 1, 32'h01010101, 0);
        drive(1, 0, 0, 0, 0, 1, 32'h01010101, 0);
        check("t3_swap_beat", $signed(po0), 10);
        drive(1, 0, 0, 0, 0, 1, 32'h01010101, 0);
        check("t3_new_weights", $signed(po0), -4);
        drive(1, 0, 0, 0, 0, 0, 32'h0, 0);
        drive(1, 0, 0, 0, 0, 0, 32'h0, 0);

        // Local accumulation
        drive(1, 1, 0, 0, 0, 0, 32'h04030201, 0);
        drive(1, 0, 1, 0, 0, 0, 32'h0, 0);
        drive(1, 0, 0, 1, 1, 1, 32'h02020202, 0);
        drive(1, 0, 0, 1, 0, 1, 32'h02020202, 0);
        check("t4_acc1", $signed(po0), 20);
        drive(1, 0, 0, 1, 0, 1, 32'h02020202, 0);
        check("t4_acc2", $signed(po0), 40);
        drive(1, 0, 0, 1, 1, 1, 32'h02020202, 0);
        check("t4_acc3", $signed(po0), 60);
        drive(1, 0, 0, 0, 0, 0, 32'h0, 0);
        check("t4_clear", $signed(po0), 20);

        // Overflow at 16-bit accumulator
        drive(1, 1, 0, 0, 0, 0, 32'h80808080, 0);
        drive(1, 0, 1, 0, 0, 0, 32'h0, 0);
        drive(1, 0, 0, 0, 0, 1, 32'h80808080, 0);
        drive(1, 0, 0, 0, 0, 0, 32'h0, 0);
        check("t5_sat_val", $signed(po1), 32767);
        check("t5_sat_flag", sf1, 1);
        check("t5_wrap_val", $signed(po2), 0);
        check("t5_wrap_flag", sf2, 1);
        check("t5_wide_val", $signed(po0), 65536);
        check("t5_wide_flag", sf0, 0);

        // Stall with beats in flight
        drive(1, 1, 0, 0, 0, 0, 32'h04030201, 0);
        drive(1, 0, 1, 0, 0, 0, 32'h0, 0);
        drive(1, 0, 0, 0, 0, 1, 32'h04030201, 5);
        drive(1, 0, 0, 0, 0, 1, 32'h01000000, -7);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 1, 1, 1, 1, $urandom, $urandom);
            check("t6_frozen_val", $signed(po0), 35);
            check("t6_frozen_valid", vo0, 1);
        end
        drive(1, 0, 0, 0, 0, 0, 32'h0, 0);
        check("t6_second", $signed(po0), -3);
        drive(1, 0, 0, 0, 0, 0, 32'h0, 0);
        check("t6_drain", vo0, 0);

        // Reset while streaming drops in-flight beats
        drive(1, 1, 0, 0, 0, 0, 32'h04030201, 0);
        drive(1, 0, 1, 0, 0, 0, 32'h0, 0);
        drive(1, 0, 0, 0, 0, 1, 32'h01010101, 3);
        drive(1, 0, 0, 0, 0, 1, 32'h01010101, 3);
        SYNC_RST = 1'b1;
        drive(1, 0, 0, 0, 0, 1, 32'h01010101, 3);
        SYNC_RST = 1'b0;
        check("t1_psum", po0, 0);
        check("t1_valid", vo0, 0);
        check("t1_toright", tr0, 0);
        drive(1, 0, 0, 0, 0, 0, 32'h0, 0);
        check("t1_no_stale", vo0, 0);

        for (int k = 0; k < 800; k++) begin
            SYNC_RST = ($urandom_range(0, 59) == 0);
            drive(($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 15),
                  $urandom_range(0, 1), ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 70),
                  $urandom,
                  ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed(10'($urandom))));
        end
        SYNC_RST = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 32'h0, 0);
        drive(1, 0, 0, 0, 0, 0, 32'h0, 0);
        checking = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
